// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared command codes, FSM states and default parameters for the MP3 key controller
package mp3_pkg;

    localparam int DEF_NUM_TRACKS  = 4;
    localparam int DEF_VOL_MAX     = 15;
    localparam int DEF_VOL_DEFAULT = 8;
    localparam int DEF_DEB_CYC     = 16;
    localparam int DEF_HL_CYC      = 50;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_NEXT  = 3'd1,
        CMD_PRE   = 3'd2,
        CMD_PLAY  = 3'd3,
        CMD_PAUSE = 3'd4,
        CMD_VOL   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // A single-track build still needs a one-bit index bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp3_key_debounce.sv
// rtl/mp3_key_debounce.sv - 2-flop synchronizer, counting debouncer and press-edge detector for one key
module mp3_key_debounce
    import mp3_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized level disagrees with the accepted level; flip on the last one.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and the registered one-cycle press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/mp3_cmd_ctrl.sv
// rtl/mp3_cmd_ctrl.sv - key-driven track/volume/play controller issuing handshaked commands to the decoder
module mp3_cmd_ctrl
    import mp3_pkg::*;
#(
    parameter int  NUM_TRACKS  = DEF_NUM_TRACKS,
    parameter int  VOL_MAX     = DEF_VOL_MAX,
    parameter int  VOL_DEFAULT = DEF_VOL_DEFAULT,
    parameter int  DEB_CYC     = DEF_DEB_CYC,
    parameter int  HL_CYC      = DEF_HL_CYC,
    localparam int TW          = idx_width(NUM_TRACKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_next,
    input  logic          i_pre,
    input  logic          i_play,
    input  logic          i_vol_plus,
    input  logic          i_vol_dec,
    output logic          o_cmd_valid,
    output logic [2:0]    o_cmd,
    input  logic          i_cmd_ready,
    output logic [TW-1:0] o_track,
    output logic [3:0]    o_vol,
    output logic          o_playing,
    output logic          o_hl_next,
    output logic          o_hl_pre,
    output logic          o_hl_vol
);

    localparam int            HW       = $clog2(HL_CYC + 1);
    localparam logic [TW-1:0] TRK_LAST = TW'(NUM_TRACKS - 1);
    localparam logic [3:0]    VMAX     = 4'(VOL_MAX);
    localparam logic [3:0]    VDEF     = 4'(VOL_DEFAULT);

    // Key order in the event vector: [4]=next [3]=pre [2]=play [1]=vol_plus [0]=vol_dec.
    logic [4:0] key_raw;
    logic [4:0] key_evt;

    assign key_raw = {i_next, i_pre, i_play, i_vol_plus, i_vol_dec};

    for (genvar k = 0; k < 5; k++) begin : g_key
        mp3_key_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_i  (key_raw[k]),
            .rise_o (key_evt[k])
        );
    end

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [TW-1:0]   track_q, track_d;
    logic [3:0]      vol_q, vol_d;
    logic            playing_q, playing_d;
    logic [HW-1:0]   hl_cnt_q, hl_cnt_d;

    // Next-state and output decode; events are only acted on in IDLE, the highest-priority one wins.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        track_d     = track_q;
        vol_d       = vol_q;
        playing_d   = playing_q;
        hl_cnt_d    = hl_cnt_q;
        o_cmd_valid = 1'b0;
        o_cmd       = CMD_NOP;
        o_hl_next   = 1'b0;
        o_hl_pre    = 1'b0;
        o_hl_vol    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_evt[4]) begin
                    track_d = (track_q == TRK_LAST) ? '0 : track_q + 1'b1;
                    cmd_d   = CMD_NEXT;
                    state_d = ST_ISSUE;
                end else if (key_evt[3]) begin
                    track_d = (track_q == '0) ? TRK_LAST : track_q - 1'b1;
                    cmd_d   = CMD_PRE;
                    state_d = ST_ISSUE;
                end else if (key_evt[2]) begin
                    playing_d = ~playing_q;
                    cmd_d     = playing_q ? CMD_PAUSE : CMD_PLAY;
                    state_d   = ST_ISSUE;
                end else if (key_evt[1]) begin
                    // At full volume the press is swallowed without a command or highlight.
                    if (vol_q < VMAX) begin
                        vol_d   = vol_q + 1'b1;
                        cmd_d   = CMD_VOL;
                        state_d = ST_ISSUE;
                    end
                end else if (key_evt[0]) begin
                    if (vol_q != 4'd0) begin
                        vol_d   = vol_q - 1'b1;
                        cmd_d   = CMD_VOL;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                o_cmd_valid = 1'b1;
                o_cmd       = cmd_q;
                if (i_cmd_ready) begin
                    hl_cnt_d = '0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_hl_next = (cmd_q == CMD_NEXT);
                o_hl_pre  = (cmd_q == CMD_PRE);
                o_hl_vol  = (cmd_q == CMD_VOL);
                if (hl_cnt_q == HW'(HL_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hl_cnt_d = hl_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and player registers; reset abandons any pending command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NOP;
            track_q   <= '0;
            vol_q     <= VDEF;
            playing_q <= 1'b0;
            hl_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            track_q   <= track_d;
            vol_q     <= vol_d;
            playing_q <= playing_d;
            hl_cnt_q  <= hl_cnt_d;
        end
    end

    assign o_track   = track_q;
    assign o_vol     = vol_q;
    assign o_playing = playing_q;

endmodule
